inst_queue: RTL and testbench

Instruction queue between the fetch stage and decode/issue. It buffers fetched instruction/PC pairs in a circular FIFO and drives back-pressure (`IQ_isfull`) to fetch with one entry of headroom for fetch's registered output. It presents the oldest entry to decode with a valid/ready handshake and flushes completely when the ROB redirects the PC.

---
 rtl/cpu_defs.sv | 16 +
 rtl/inst_queue_if.sv | 34 +++
 rtl/iq_ram.sv | 27 ++
 rtl/inst_queue.sv | 102 ++++++++++
 tb/tb_inst_queue.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU widths, constants and the instruction-queue entry type
package cpu_defs;

    localparam int InstSize = 32;
    localparam int REGSize  = 32;

    localparam logic one  = 1'b1;
    localparam logic zero = 1'b0;

    // One fetched instruction together with its PC.
    typedef struct packed {
        logic [InstSize-1:0] inst;
        logic [REGSize-1:0]  pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch-side and decode-side handshake bundle of the instruction queue
// Fetch side : if_valid/if_inst/if_pc in, IQ_isfull back-pressure out.
// Decode side: dec_ready in, iq_valid/iq_inst/iq_pc head entry out, iq_count occupancy out.
// slave is the queue's view, master is the view of the fetch/decode pair driving it.
interface inst_queue_if
    import cpu_defs::*;
#(
    parameter int INST_W = InstSize,
    parameter int PC_W   = REGSize,
    parameter int CNT_W  = 5
) ();

    logic              if_valid;
    logic [INST_W-1:0] if_inst;
    logic [PC_W-1:0]   if_pc;
    logic              IQ_isfull;

    logic              dec_ready;
    logic              iq_valid;
    logic [INST_W-1:0] iq_inst;
    logic [PC_W-1:0]   iq_pc;
    logic [CNT_W-1:0]  iq_count;

    modport slave (
        input  if_valid, if_inst, if_pc, dec_ready,
        output IQ_isfull, iq_valid, iq_inst, iq_pc, iq_count
    );

    modport master (
        output if_valid, if_inst, if_pc, dec_ready,
        input  IQ_isfull, iq_valid, iq_inst, iq_pc, iq_count
    );

endinterface

// File: rtl/iq_ram.sv
// rtl/iq_ram.sv - DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port
// Ports: clk_in, we/waddr/wdata write port, raddr in, rdata out (combinational).
module iq_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are never cleared; occupancy tracking decides what is meaningful.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular instruction FIFO between fetch and decode with ROB flush
// Ports: clk_in clock, rst_in async active-low reset, rdy_in global enable,
//        commit_en flush, q fetch/decode handshake bundle (slave view).
// DEPTH must be a power of two and at least 4 so the pointers wrap for free.
module inst_queue
    import cpu_defs::*;
#(
    parameter int DEPTH  = 16,
    parameter int INST_W = InstSize,
    parameter int PC_W   = REGSize
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          commit_en,
    inst_queue_if.slave   q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = INST_W + PC_W;

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             active;
    logic             flush;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] rdata;

    assign active = rdy_in && !commit_en;
    assign flush  = rdy_in && commit_en;
    assign pop    = active && (count_q != '0) && q.dec_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push   = active && q.if_valid && ((count_q != CNT_FULL) || pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + {{PTR_W{zero}}, push} - {{PTR_W{zero}}, pop};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    iq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk_in (clk_in),
        .we     (push),
        .waddr  (tail_q),
        .wdata  ({q.if_inst, q.if_pc}),
        .raddr  (head_q),
        .rdata  (rdata)
    );

    // First-word fall-through: the head entry is always on the outputs.
    assign q.iq_valid  = (count_q != '0);
    assign q.iq_inst   = rdata[ENT_W-1:PC_W];
    assign q.iq_pc     = rdata[PC_W-1:0];
    assign q.iq_count  = count_q;
    // Asserted one entry early so the instruction fetch already holds still fits.
    assign q.IQ_isfull = (count_q >= CNT_ALMOST);

    // Fetch ignored back-pressure: the entry is lost.
    always @(posedge clk_in) begin
        if (rst_in && active) begin
            assert (!(q.if_valid && (count_q == CNT_FULL) && !pop))
                else $warning("inst_queue: push dropped while queue full");
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - randomized self-checking bench for inst_queue against a queue model
module tb_inst_queue;
    import cpu_defs::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic clk_in    = 1'b0;
    logic rst_in    = 1'b0;
    logic rdy_in    = 1'b0;
    logic commit_en = 1'b0;

    inst_queue_if #(.INST_W(InstSize), .PC_W(REGSize), .CNT_W(CNT_W)) q ();

    inst_queue #(
        .DEPTH  (DEPTH),
        .INST_W (InstSize),
        .PC_W   (REGSize)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .commit_en (commit_en),
        .q         (q.slave)
    );

    always #5 clk_in = ~clk_in;

    iq_entry_t model [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        int sz;
        sz = model.size();
        check({tag, ".count"}, 64'(q.iq_count), 64'(sz));
        check({tag, ".valid"}, 64'(q.iq_valid), 64'(sz != 0));
        check({tag, ".isfull"}, 64'(q.IQ_isfull), 64'(sz >= DEPTH - 1));
        if (sz != 0) begin
            check({tag, ".pc"}, 64'(q.iq_pc), 64'(model[0].pc));
            check({tag, ".inst"}, 64'(q.iq_inst), 64'(model[0].inst));
        end
    endtask

    // Drive one cycle of inputs, advance the model by the queue rules, check after the edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic rd, input logic cm, input logic rdy, input string tag);
        bit do_pop;
        bit do_push;
        q.if_valid  = v;
        q.if_inst   = ins;
        q.if_pc     = p;
        q.dec_ready = rd;
        commit_en   = cm;
        rdy_in      = rdy;
        if (rdy) begin
            if (cm) begin
                model.delete();
            end else begin
                do_pop  = (model.size() != 0) && rd;
                do_push = v && ((model.size() < DEPTH) || do_pop);
                if (do_pop) void'(model.pop_front());
                if (do_push) model.push_back(iq_entry_t'{inst: ins, pc: p});
            end
        end
        @(posedge clk_in);
        @(negedge clk_in);
        check_outputs(tag);
    endtask

    initial begin
        q.if_valid  = 1'b0;
        q.if_inst   = '0;
        q.if_pc     = '0;
        q.dec_ready = 1'b0;

        // Reset state
        @(negedge clk_in);
        check("reset.valid", 64'(q.iq_valid), 64'(0));
        check("reset.isfull", 64'(q.IQ_isfull), 64'(0));
        check("reset.count", 64'(q.iq_count), 64'(0));
        rst_in = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "idle");

        // Fill to DEPTH with decode stalled, then one push that must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'hA000_0000 + 32'(i), 32'(i * 4), 1'b0, 1'b0, 1'b1, "fill");
            check("fill.isfull_dir", 64'(q.IQ_isfull), 64'(i >= DEPTH - 2));
        end
        step(1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 1'b0, 1'b0, 1'b1, "overflow");
        check("overflow.count16", 64'(q.iq_count), 64'(16));

        // Drain: PCs must come out 0x0, 0x4, ... 0x3C
        for (int i = 0; i < DEPTH; i++) begin
            check("drain.order", 64'(q.iq_pc), 64'(i * 4));
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, "drain");
        end

        // Refill, then sustained push+pop at full occupancy across the wrap
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, $urandom, 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 1'b1, "refill");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, $urandom, 32'h2000 + 32'(i * 4), 1'b1, 1'b0, 1'b1, "wrap");
            check("wrap.count16", 64'(q.iq_count), 64'(16));
        end

        // Flush at count 7 with push and pop also requested
        for (int i = 0; i < DEPTH - 7; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, "to7");
        check("to7.count", 64'(q.iq_count), 64'(7));
        step(1'b1, 32'h1234_5678, 32'h0000_0F00, 1'b1, 1'b1, 1'b1, "flush");
        check("flush.count0", 64'(q.iq_count), 64'(0));
        check("flush.valid0", 64'(q.iq_valid), 64'(0));
        step(1'b1, 32'h0BAD_F00D, 32'h0000_0100, 1'b0, 1'b0, 1'b1, "postflush");
        check("postflush.pc", 64'(q.iq_pc), 64'h100);

        // Global enable low: nothing moves, flush ignored
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom, 32'h3000 + 32'(i * 4), 1'b0, 1'b0, 1'b1, "prehold");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, 32'h4000, 1'b1, 1'(i % 2), 1'b0, "hold");
            check("hold.count4", 64'(q.iq_count), 64'(4));
            check("hold.pc", 64'(q.iq_pc), 64'h100);
        end
        step(1'b1, $urandom, 32'h5000, 1'b1, 1'b0, 1'b1, "resume");

        // Asynchronous reset mid-stream at count 5
        for (int i = 0; i < 8 && model.size() < 5; i++)
            step(1'b1, $urandom, 32'h6000 + 32'(i * 4), 1'b0, 1'b0, 1'b1, "to5");
        check("to5.count", 64'(q.iq_count), 64'(5));
        #2;
        rst_in = 1'b0;
        #1;
        check("areset.count", 64'(q.iq_count), 64'(0));
        check("areset.valid", 64'(q.iq_valid), 64'(0));
        check("areset.isfull", 64'(q.IQ_isfull), 64'(0));
        model.delete();
        @(negedge clk_in);
        rst_in = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "postreset");

        // Random traffic; fetch honours the hard full limit so no entry is dropped
        for (int i = 0; i < 10000; i++) begin
            logic v, rd, cm, rdy;
            rd  = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 9) != 0);
            cm  = ($urandom_range(0, 49) == 0);
            v   = 1'($urandom_range(0, 1)) && !((model.size() == DEPTH) && !rd);
            step(v, $urandom, $urandom, rd, cm, rdy, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
